// File: rtl/dadda.sv
// rtl/dadda.sv - 32x32 RISC-V M-extension multiplier: Dadda tree + CPA, 3-cycle latency
package mult_funct3;
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011
  } mult_funct3_t;
endpackage

module dadda #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           mult_op,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   C,
  output logic                 o_rdy,
  output logic                 mult_stall
);
  import mult_funct3::*;

  localparam int N      = WIDTH + 1;
  localparam int NCOL   = 2 * WIDTH;
  localparam int NSTAGE = 8;
  localparam int SCHED [NSTAGE] = '{28, 19, 13, 9, 6, 4, 3, 2};

  // DONE is encoded as the number of edges elapsed since the sampling edge
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    DONE = 2'(LATENCY)
  } state_t;

  state_t state, state_n;
  logic   launch;

  logic           a_sgn, b_sgn;
  logic [N-1:0]   a_ext, b_ext;
  logic [N-1:0]   pp_d [N];
  logic [N-1:0]   pp_q [N];

  logic [N-1:0]   cur [NCOL+1];
  logic [N-1:0]   nxt [NCOL+1];
  int             ht  [NCOL+1];
  int             hn  [NCOL+1];
  int             d, cin, exc, nfa, nha, src;
  logic           x, y, z;
  logic [NCOL-1:0] row_s, row_c;
  logic [NCOL-1:0] sum_q, car_q;

  assign launch     = start && (state == IDLE || state == DONE);
  assign mult_stall = start || (state == S1) || (state == S2);
  assign o_rdy      = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = S1;
      S1:      state_n = S2;
      S2:      state_n = DONE;
      DONE:    if (start) state_n = S1;
      default: state_n = IDLE;
    endcase
  end

  // Modified Baugh-Wooley array on 33-bit extended operands; the 2^33
  // correction constant is injected into the tree, the 2^65 one falls off the top.
  always_comb begin
    pp_d  = '{default: '0};
    a_sgn = (mult_op == MUL) || (mult_op == MULH) || (mult_op == MULHSU);
    b_sgn = (mult_op == MUL) || (mult_op == MULH);
    a_ext = {a_sgn & A[WIDTH-1], A};
    b_ext = {b_sgn & B[WIDTH-1], B};
    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        pp_d[j][i] = (a_ext[i] & b_ext[j]) ^ ((i == N-1) != (j == N-1));
  end

  // Column-wise Dadda reduction; column NCOL only catches carries that are discarded
  always_comb begin
    cur   = '{default: '0};
    nxt   = '{default: '0};
    ht    = '{default: 0};
    hn    = '{default: 0};
    d     = 0;
    cin   = 0;
    exc   = 0;
    nfa   = 0;
    nha   = 0;
    src   = 0;
    x     = 1'b0;
    y     = 1'b0;
    z     = 1'b0;
    row_s = '0;
    row_c = '0;

    for (int j = 0; j < N; j++)
      for (int i = 0; i < N; i++)
        if (i + j < NCOL) begin
          cur[i+j][ht[i+j]] = pp_q[j][i];
          ht[i+j] = ht[i+j] + 1;
        end
    cur[N][ht[N]] = 1'b1;
    ht[N] = ht[N] + 1;

    for (int s = 0; s < NSTAGE; s++) begin
      d   = SCHED[s];
      cin = 0;
      nxt = '{default: '0};
      hn  = '{default: 0};
      for (int c = 0; c < NCOL; c++) begin
        hn[c] = cin;
        exc   = ht[c] + cin - d;
        nfa   = (exc > 0) ? exc / 2 : 0;
        nha   = (exc > 0) ? exc % 2 : 0;
        src   = 0;
        for (int k = 0; k < N; k++)
          if (k < nfa) begin
            x = cur[c][src];
            y = cur[c][src+1];
            z = cur[c][src+2];
            nxt[c][hn[c]] = x ^ y ^ z;
            nxt[c+1][k]   = (x & y) | (z & (x ^ y));
            hn[c] = hn[c] + 1;
            src   = src + 3;
          end
        if (nha == 1) begin
          x = cur[c][src];
          y = cur[c][src+1];
          nxt[c][hn[c]] = x ^ y;
          nxt[c+1][nfa] = x & y;
          hn[c] = hn[c] + 1;
          src   = src + 2;
        end
        for (int k = 0; k < N; k++)
          if (k >= src && k < ht[c]) begin
            nxt[c][hn[c]] = cur[c][k];
            hn[c] = hn[c] + 1;
          end
        cin = nfa + nha;
      end
      cur = nxt;
      ht  = hn;
    end

    for (int c = 0; c < NCOL; c++) begin
      row_s[c] = cur[c][0];
      row_c[c] = cur[c][1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pp_q  <= '{default: '0};
      sum_q <= '0;
      car_q <= '0;
      C     <= '0;
    end else begin
      if (launch)       pp_q <= pp_d;
      if (state == S1) begin
        sum_q <= row_s;
        car_q <= row_c;
      end
      if (state == S2)  C <= sum_q + car_q;
    end
  end

endmodule

// File: tb/tb_dadda.sv
// tb/tb_dadda.sv - directed self-checking bench for the dadda multiplier
module tb_dadda;
  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mult_op;
  logic [31:0] A;
  logic [31:0] B;
  logic [63:0] C;
  logic        o_rdy;
  logic        mult_stall;

  int vectors;
  int miscompares;

  dadda #(.WIDTH(32), .LATENCY(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mult_op    (mult_op),
    .A          (A),
    .B          (B),
    .C          (C),
    .o_rdy      (o_rdy),
    .mult_stall (mult_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Launch at a negedge, scramble operands mid-flight, check each stage
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    mult_op = op;
    A       = a;
    B       = b;
    start   = 1'b1;
    #1 chk({tag, "_stall_req"}, 64'(mult_stall), 64'd1);
    @(negedge clk);
    start   = 1'b0;
    A       = ~a;
    B       = b ^ 32'h5A5A_A5A5;
    mult_op = ~op;
    chk({tag, "_s1_rdy"}, 64'(o_rdy), 64'd0);
    chk({tag, "_s1_stall"}, 64'(mult_stall), 64'd1);
    @(negedge clk);
    chk({tag, "_s2_rdy"}, 64'(o_rdy), 64'd0);
    chk({tag, "_s2_stall"}, 64'(mult_stall), 64'd1);
    @(negedge clk);
    chk({tag, "_c"}, C, exp);
    chk({tag, "_rdy"}, 64'(o_rdy), 64'd1);
    chk({tag, "_stall"}, 64'(mult_stall), 64'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst     = 1'b0;
    start   = 1'b0;
    mult_op = 3'b000;
    A       = 32'h0;
    B       = 32'h0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_c", C, 64'd0);
    chk("rst_rdy", 64'(o_rdy), 64'd0);
    chk("rst_stall", 64'(mult_stall), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_c", C, 64'd0);
    chk("idle_rdy", 64'(o_rdy), 64'd0);
    chk("idle_stall", 64'(mult_stall), 64'd0);

    run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "mulhu_max");
    run_op(3'b001, 32'd12,        32'h8000_0000, 64'hFFFF_FFFA_0000_0000, "mulh_12_min");
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1,                   "mulh_m1_m1");
    run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_0000_0001, "mulhsu_m1_max");
    run_op(3'b010, 32'd7,         32'd9,         64'd63,                  "mulhsu_7_9");
    run_op(3'b000, 32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "mul_m3_5");
    run_op(3'b111, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE, "op111_as_mulhu");
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_8000_0000, "mulhsu_min_max");
    run_op(3'b001, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, "mulh_max_min");
    run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mulhu_msb_msb");
    run_op(3'b000, 32'h1234_5678, 32'h0001_0000, 64'h0000_1234_5678_0000, "mul_shift16");
    run_op(3'b011, 32'hDEAD_BEEF, 32'd1,         64'h0000_0000_DEAD_BEEF, "mulhu_id");
    run_op(3'b001, 32'hDEAD_BEEF, 32'd1,         64'hFFFF_FFFF_DEAD_BEEF, "mulh_id");

    for (int a = 0; a < 15; a++)
      for (int b = 0; b < 15; b++)
        run_op(3'b010, 32'(a), 32'(b), 64'(a * b), $sformatf("mulhsu_sw_%0d_%0d", a, b));

    for (int k = 0; k < 16; k++)
      run_op(3'b001, 32'd12, 32'h8000_0000 + 32'(k),
             64'hFFFF_FFFA_0000_0000 + 64'(12 * k), $sformatf("mulh_sw_%0d", k));

    // start pulsed while in S1 must be dropped
    mult_op = 3'b001;
    A       = 32'd1000;
    B       = 32'hFFFF_FFFD;
    start   = 1'b1;
    @(negedge clk);
    A       = 32'd5;
    B       = 32'd5;
    mult_op = 3'b011;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    chk("s1start_s2_rdy", 64'(o_rdy), 64'd0);
    chk("s1start_s2_stall", 64'(mult_stall), 64'd1);
    @(negedge clk);
    chk("s1start_c", C, 64'hFFFF_FFFF_FFFF_F448);
    chk("s1start_rdy", 64'(o_rdy), 64'd1);
    @(negedge clk);
    chk("s1start_hold_c", C, 64'hFFFF_FFFF_FFFF_F448);
    chk("s1start_hold_rdy", 64'(o_rdy), 64'd1);
    chk("s1start_hold_stall", 64'(mult_stall), 64'd0);

    // reset while in S2 aborts the operation
    mult_op = 3'b011;
    A       = 32'hFFFF_FFFF;
    B       = 32'hFFFF_FFFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    @(negedge clk);
    chk("abort_rdy", 64'(o_rdy), 64'd0);
    chk("abort_c", C, 64'd0);
    chk("abort_stall", 64'(mult_stall), 64'd0);
    rst     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_after_rdy", 64'(o_rdy), 64'd0);
    chk("abort_after_c", C, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
